mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter WAIT_MAX, default 15, the most cycles it waits for dmem_ack before flagging a bus error.
REQ-003 clk  in  1  clock; all state SHALL change on the rising edge only.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 alu_res_in  in  XLEN  effective address or ALU result, from the EX/MEM register.
REQ-006 reg_data2_in  in  XLEN  store data.
REQ-007 rd_in  in  5  destination register.
REQ-008 funct3_in  in  3  access size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000, 001, 010.
REQ-009 memRead_in, memWrite_in, memtoReg_in, regWrite_in  in  1 each  control bits from the EX/MEM register.
REQ-010 qed_vld_in  in  1  SQED valid tag from the EX/MEM register.
REQ-011 dmem_req, dmem_we  out  1 each  memory request and write enable.
REQ-012 dmem_addr  out  XLEN  word-aligned address, equal to {alu_res_in[XLEN-1:2], 2'b00}.
REQ-013 dmem_wdata  out  XLEN  lane-replicated store data; dmem_be  out  4  byte enables.
REQ-014 dmem_ack  in  1  request complete; dmem_rdata  in  XLEN  read word, valid when dmem_ack=1.
REQ-015 mem_stall  out  1  high → upstream SHALL hold the EX/MEM register (write=0).
REQ-016 MEM/WB outputs, all registered: wb_data_out XLEN, rd_out 5, regWrite_out 1, qed_vld_out_mem_wb 1, mem_err_out 1.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT, ERR.
REQ-018 Memory op present (memRead_in|memWrite_in) in IDLE → dmem_req=1 combinationally in that cycle.
REQ-019 dmem_req, dmem_addr, dmem_we, dmem_wdata and dmem_be SHALL stay stable until the cycle dmem_ack=1.
REQ-020 ack in the same cycle → FSM stays in IDLE, zero stall; no ack → go to WAIT.
REQ-021 mem_stall = op present & ~dmem_ack, in both IDLE and WAIT.
REQ-022 MEM/WB SHALL load only when the stage completes: non-memory op any cycle, or memory op with dmem_ack=1.
REQ-023 While stalled, MEM/WB SHALL be written with a bubble: regWrite_out=0, qed_vld_out_mem_wb=0.
REQ-024 Load data SHALL select the byte or half lane by alu_res_in[1:0], then sign- or zero-extend per funct3.
REQ-025 wb_data_out = extended load data if memtoReg_in, else alu_res_in.
REQ-026 Store SHALL replicate the byte or half across lanes and set be to 0001<<a[1:0] for SB, 0011<<{a[1],0} for SH, or 1111 for SW.
REQ-027 WAIT counter SHALL reach WAIT_MAX without ack → state ERR, dmem_req=0, mem_err_out=1 (sticky), mem_stall=1 permanently.
REQ-028 memRead_in and memWrite_in both 1 SHALL be treated as a store.
REQ-029 A non-memory op SHALL have latency of 1 cycle into MEM/WB; a memory op SHALL have latency of 1 + wait cycles.

Reset
REQ-030 Reset SHALL take priority over all other events, including an outstanding ack, and return the FSM to IDLE.
REQ-031 Reset SHALL clear the counter and all MEM/WB outputs to 0, and drive dmem_req=0.
REQ-032 Reset mid-WAIT SHALL abandon the request; a late dmem_ack while in IDLE with no op SHALL be ignored.

Configuration
REQ-033 With MEM_MISALIGN_CHECK_EN defined, a misaligned access (LH/LHU/SH with a[0]=1, LW/SW with a[1:0]≠0) SHALL raise no dmem_req and no stall.
REQ-034 With MEM_MISALIGN_CHECK_EN defined, such an access SHALL write MEM/WB with regWrite_out=0 and mem_err_out=1.
REQ-035 Without the macro, the low address bits SHALL be forced to alignment and no check is made.

Structure
REQ-036 Package mem_pkg SHALL hold the state enum, the funct3 encodings and the byte-enable constants.
REQ-037 Sub-module mem_load_align SHALL implement the combinational lane select and extension.

Verification
REQ-038 LW at 0x100, ack same cycle, rdata=0xDEADBEEF → mem_stall never 1, wb_data_out=0xDEADBEEF, regWrite_out=1 next edge.
REQ-039 LB at 0x103, rdata=0x80112233, ack after 3 cycles → mem_stall high for 3 cycles, three bubbles, then wb_data_out=0xFFFFFF80.
REQ-040 SH at 0x102, data 0x0000ABCD → dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, regWrite_out=0.
REQ-041 LW with no ack for WAIT_MAX=15 cycles → ERR, mem_err_out=1, dmem_req=0; then reset → all outputs 0, state IDLE.
REQ-042 With MEM_MISALIGN_CHECK_EN, LW at 0x101 → dmem_req=0, mem_err_out=1, regWrite_out=0; without it, dmem_addr=0x100 and a normal load.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory pipeline stage.
//   mem_state_e   - handshake FSM states (idle, waiting for ack, bus error)
//   Funct3*       - RISC-V load/store size and sign encodings
//   Be*           - unshifted byte-enable patterns for byte/half/word accesses
//   is_misaligned - true when an access is not naturally aligned
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StErr  = 2'b10
    } mem_state_e;

    localparam logic [2:0] Funct3Lb  = 3'b000;
    localparam logic [2:0] Funct3Lh  = 3'b001;
    localparam logic [2:0] Funct3Lw  = 3'b010;
    localparam logic [2:0] Funct3Lbu = 3'b100;
    localparam logic [2:0] Funct3Lhu = 3'b101;
    localparam logic [2:0] Funct3Sb  = 3'b000;
    localparam logic [2:0] Funct3Sh  = 3'b001;
    localparam logic [2:0] Funct3Sw  = 3'b010;

    localparam logic [3:0] BeByte = 4'b0001;
    localparam logic [3:0] BeHalf = 4'b0011;
    localparam logic [3:0] BeWord = 4'b1111;

    // Store encodings alias the signed loads, so one decode covers both.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3)
            Funct3Lh, Funct3Lhu: mis = addr_lo[0];
            Funct3Lw:            mis = (addr_lo != 2'b00);
            default:             mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus.
//   dmem_req   - request valid, held until dmem_ack
//   dmem_we    - write enable
//   dmem_addr  - word-aligned address
//   dmem_wdata - lane-replicated store data
//   dmem_be    - byte enables
//   dmem_ack   - request complete this cycle
//   dmem_rdata - read word, valid with dmem_ack
// Modports: master (pipeline stage), slave (memory).
interface mem_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load lane select and extension.
//   rdata     - raw word from memory
//   addr_lo   - low two bits of the effective address
//   funct3    - load size/sign encoding
//   load_data - extended value for write-back
module mem_load_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        lane_byte = rdata[{addr_lo, 3'b000} +: 8];
        // addr_lo[0] is ignored, so an odd half-word address reads its containing half.
        lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            Funct3Lb:  load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
            Funct3Lh:  load_data = {{(XLEN-16){lane_half[15]}}, lane_half};
            Funct3Lbu: load_data = {{(XLEN-8){1'b0}}, lane_byte};
            Funct3Lhu: load_data = {{(XLEN-16){1'b0}}, lane_half};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with data-memory handshake and MEM/WB register.
//   clk, reset            - clock, synchronous active-high reset
//   alu_res_in            - effective address / ALU result
//   reg_data2_in          - store data
//   rd_in, funct3_in      - destination register, access size/sign
//   memRead_in .. qed_vld_in - EX/MEM control bits
//   dmem                  - data-memory bus (master side)
//   mem_stall             - hold EX/MEM while the access is outstanding
//   wb_data_out .. mem_err_out - registered MEM/WB outputs
// Optional feature: define MEM_MISALIGN_CHECK_EN to turn misaligned accesses into
// errored MEM/WB entries instead of silently aligning them.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_res_in,
    input  logic [XLEN-1:0] reg_data2_in,
    input  logic [4:0]      rd_in,
    input  logic [2:0]      funct3_in,
    input  logic            memRead_in,
    input  logic            memWrite_in,
    input  logic            memtoReg_in,
    input  logic            regWrite_in,
    input  logic            qed_vld_in,
    mem_stage_if.master     dmem,
    output logic            mem_stall,
    output logic [XLEN-1:0] wb_data_out,
    output logic [4:0]      rd_out,
    output logic            regWrite_out,
    output logic            qed_vld_out_mem_wb,
    output logic            mem_err_out
);

    localparam int unsigned     CntW        = $clog2(WAIT_MAX + 1);
    localparam logic [CntW-1:0] LastCnt     = CntW'(WAIT_MAX - 1);
    localparam bit              IdleTimeout = (WAIT_MAX <= 1);

    mem_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            op, misalign, req, complete;
    logic [XLEN-1:0] load_data;

    // Both memRead_in and memWrite_in set is a store: memWrite_in alone decides direction.
    assign op = memRead_in | memWrite_in;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = op & is_misaligned(funct3_in, alu_res_in[1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt counts request cycles that have gone unacknowledged.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (op && !misalign && !dmem.dmem_ack) begin
                    if (IdleTimeout) begin
                        state_d = StErr;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            StWait: begin
                if (dmem.dmem_ack) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q >= LastCnt) begin
                    state_d = StErr;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req       = 1'b0;
        mem_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                req       = op & ~misalign;
                mem_stall = op & ~misalign & ~dmem.dmem_ack;
            end
            StWait: begin
                req       = op;
                mem_stall = op & ~dmem.dmem_ack;
            end
            StErr:   mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
        complete = (state_q != StErr) & ~mem_stall;
        if (reset) begin
            req       = 1'b0;
            mem_stall = 1'b0;
        end
    end

    assign dmem.dmem_req = req;

    // Bus fields derive straight from EX/MEM, which is held while stalled, so they stay stable.
    always_comb begin
        dmem.dmem_addr = {alu_res_in[XLEN-1:2], 2'b00};
        dmem.dmem_we   = req & memWrite_in;
        dmem.dmem_be   = BeWord;
        dmem.dmem_wdata = '0;
        if (memWrite_in) begin
            case (funct3_in)
                Funct3Sb: begin
                    dmem.dmem_be    = BeByte << alu_res_in[1:0];
                    dmem.dmem_wdata = {(XLEN/8){reg_data2_in[7:0]}};
                end
                Funct3Sh: begin
                    dmem.dmem_be    = BeHalf << {alu_res_in[1], 1'b0};
                    dmem.dmem_wdata = {(XLEN/16){reg_data2_in[15:0]}};
                end
                default: begin
                    dmem.dmem_be    = BeWord;
                    dmem.dmem_wdata = reg_data2_in;
                end
            endcase
        end
    end

    mem_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .rdata     (dmem.dmem_rdata),
        .addr_lo   (alu_res_in[1:0]),
        .funct3    (funct3_in),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_out        <= '0;
            rd_out             <= '0;
            regWrite_out       <= 1'b0;
            qed_vld_out_mem_wb <= 1'b0;
            mem_err_out        <= 1'b0;
        end else if (complete) begin
            wb_data_out        <= (memtoReg_in && !misalign) ? load_data : alu_res_in;
            rd_out             <= rd_in;
            regWrite_out       <= regWrite_in & ~misalign;
            qed_vld_out_mem_wb <= qed_vld_in;
            mem_err_out        <= misalign;
        end else begin
            // Bubble; the error flag sticks once the FSM has given up on the bus.
            regWrite_out       <= 1'b0;
            qed_vld_out_mem_wb <= 1'b0;
            mem_err_out        <= (state_d == StErr);
        end
    end

endmodule
